// File: rtl/rom_loader.sv
// rom_loader: boot-time sequencer that streams a length-prefixed word image into the
// Hack instruction ROM and holds the CPU in reset until it lands. Define ROM_LOADER_CHECKSUM_EN
// to require a trailing XOR checksum byte after the payload.
module rom_loader #(
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [7:0]            in_byte,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  rom_we,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    output logic [15:0]           rom_data,
    output logic                  cpu_reset,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_LEN_HI,
        ST_LEN_LO,
        ST_DATA_HI,
        ST_DATA_LO,
        ST_WRITE,
`ifdef ROM_LOADER_CHECKSUM_EN
        ST_CSUM,
`endif
        ST_DONE,
        ST_ERROR
    } state_t;

    localparam logic [16:0] CAPACITY = 17'd1 << ADDR_WIDTH;

    state_t                state_q;
    logic [15:0]           len_q;
    logic [ADDR_WIDTH:0]   cnt_q;
    logic [7:0]            hi_q;
    logic                  in_ready_q;
    logic                  rom_we_q;
    logic [ADDR_WIDTH-1:0] rom_addr_q;
    logic [15:0]           rom_data_q;
    logic                  cpu_reset_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  error_q;
`ifdef ROM_LOADER_CHECKSUM_EN
    logic [7:0]            csum_q;
`endif

    logic        xfer;
    logic [15:0] len_d;
    logic [16:0] cntNext_d;

    assign xfer      = in_valid && in_ready_q;
    assign len_d     = {len_q[15:8], in_byte};
    assign cntNext_d = 17'(cnt_q) + 17'd1;

    // Outputs are registered alongside the state, so each branch sets the values the
    // next state must present on its first cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            len_q       <= '0;
            cnt_q       <= '0;
            hi_q        <= '0;
            in_ready_q  <= 1'b0;
            rom_we_q    <= 1'b0;
            rom_addr_q  <= '0;
            rom_data_q  <= '0;
            cpu_reset_q <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
`ifdef ROM_LOADER_CHECKSUM_EN
            csum_q      <= '0;
`endif
        end else begin
            rom_we_q <= 1'b0;
            case (state_q)
                ST_IDLE, ST_DONE, ST_ERROR: begin
                    if (start) begin
                        state_q     <= ST_LEN_HI;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b1;
                        cpu_reset_q <= 1'b1;
                        done_q      <= 1'b0;
                        error_q     <= 1'b0;
`ifdef ROM_LOADER_CHECKSUM_EN
                        csum_q      <= '0;
`endif
                    end
                end
                ST_LEN_HI: begin
                    if (xfer) begin
                        len_q[15:8] <= in_byte;
                        state_q     <= ST_LEN_LO;
                    end
                end
                ST_LEN_LO: begin
                    if (xfer) begin
                        len_q <= len_d;
                        cnt_q <= '0;
                        if (len_d == 16'd0) begin
`ifdef ROM_LOADER_CHECKSUM_EN
                            state_q     <= ST_CSUM;
`else
                            state_q     <= ST_DONE;
                            in_ready_q  <= 1'b0;
                            busy_q      <= 1'b0;
                            done_q      <= 1'b1;
                            cpu_reset_q <= 1'b0;
`endif
                        end else if ({1'b0, len_d} > CAPACITY) begin
                            state_q    <= ST_ERROR;
                            in_ready_q <= 1'b0;
                            busy_q     <= 1'b0;
                            error_q    <= 1'b1;
                        end else begin
                            state_q <= ST_DATA_HI;
                        end
                    end
                end
                ST_DATA_HI: begin
                    if (xfer) begin
                        hi_q    <= in_byte;
                        state_q <= ST_DATA_LO;
`ifdef ROM_LOADER_CHECKSUM_EN
                        csum_q  <= csum_q ^ in_byte;
`endif
                    end
                end
                ST_DATA_LO: begin
                    if (xfer) begin
                        rom_we_q   <= 1'b1;
                        rom_addr_q <= cnt_q[ADDR_WIDTH-1:0];
                        rom_data_q <= {hi_q, in_byte};
                        in_ready_q <= 1'b0;
                        state_q    <= ST_WRITE;
`ifdef ROM_LOADER_CHECKSUM_EN
                        csum_q     <= csum_q ^ in_byte;
`endif
                    end
                end
                ST_WRITE: begin
                    cnt_q <= cntNext_d[ADDR_WIDTH:0];
                    if (cntNext_d == {1'b0, len_q}) begin
`ifdef ROM_LOADER_CHECKSUM_EN
                        state_q     <= ST_CSUM;
                        in_ready_q  <= 1'b1;
`else
                        state_q     <= ST_DONE;
                        busy_q      <= 1'b0;
                        done_q      <= 1'b1;
                        cpu_reset_q <= 1'b0;
`endif
                    end else begin
                        state_q    <= ST_DATA_HI;
                        in_ready_q <= 1'b1;
                    end
                end
`ifdef ROM_LOADER_CHECKSUM_EN
                ST_CSUM: begin
                    if (xfer) begin
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b0;
                        if (in_byte == csum_q) begin
                            state_q     <= ST_DONE;
                            done_q      <= 1'b1;
                            cpu_reset_q <= 1'b0;
                        end else begin
                            state_q <= ST_ERROR;
                            error_q <= 1'b1;
                        end
                    end
                end
`endif
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign rom_we    = rom_we_q;
    assign rom_addr  = rom_addr_q;
    assign rom_data  = rom_data_q;
    assign cpu_reset = cpu_reset_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign error     = error_q;

endmodule

// File: tb/tb_rom_loader.sv
// tb_rom_loader: directed and randomized loads of rom_loader checked against a word-list model
// of the stream format; follows ROM_LOADER_CHECKSUM_EN when defined.
module tb_rom_loader;

    localparam int AW  = 12;
    localparam int CAP = 1 << AW;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [7:0]    in_byte;
    logic          in_valid;
    logic          in_ready;
    logic          rom_we;
    logic [AW-1:0] rom_addr;
    logic [15:0]   rom_data;
    logic          cpu_reset;
    logic          busy;
    logic          done;
    logic          error;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int lastWeCyc = -1;
    int fallCyc = -1;
    int weReadyViol = 0;
    int weBackToBack = 0;
    logic prevWe = 1'b0;
    logic prevCpuReset = 1'b1;

    logic [AW-1:0] wrAddrQ[$];
    logic [15:0]   wrDataQ[$];
    logic [15:0]   wordQ[$];
    logic [7:0]    streamQ[$];

    rom_loader #(.ADDR_WIDTH(AW)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .in_byte   (in_byte),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .rom_we    (rom_we),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .cpu_reset (cpu_reset),
        .busy      (busy),
        .done      (done),
        .error     (error)
    );

    always #5 clk = ~clk;

    // Record every ROM write and the cycle cpu_reset is released, sampled just after each edge.
    always @(posedge clk) begin
        #1;
        cyc++;
        if (rom_we) begin
            wrAddrQ.push_back(rom_addr);
            wrDataQ.push_back(rom_data);
            lastWeCyc = cyc;
            if (in_ready) weReadyViol++;
            if (prevWe) weBackToBack++;
        end
        if (prevCpuReset && !cpu_reset) fallCyc = cyc;
        prevWe       = rom_we;
        prevCpuReset = cpu_reset;
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Feed streamQ; mode 0 holds in_valid, 1 toggles it, 2 randomizes it. Noise adds stray start pulses.
    task automatic applyStimulus(input int mode, input bit noise, input string tag);
        int idx    = 0;
        int spent  = 0;
        int budget = 8 * streamQ.size() + 50;
        bit phase  = 1'b0;
        while (idx < streamQ.size() && spent < budget) begin
            @(negedge clk);
            spent++;
            case (mode)
                0:       in_valid = 1'b1;
                1:       begin phase = ~phase; in_valid = phase; end
                default: in_valid = ($urandom_range(0, 2) != 0);
            endcase
            in_byte = streamQ[idx];
            start   = noise && ($urandom_range(0, 5) == 0);
            if (in_valid && in_ready) idx++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        start    = 1'b0;
        in_byte  = 8'h00;
        checkOutput({tag, "_bytesAccepted"}, idx, streamQ.size());
    endtask

    task automatic pulseStart();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic runLoad(input string tag, input int n, input int mode, input bit noise, input bit corrupt);
        bit         inRange = (n <= CAP);
        logic [7:0] xorSum  = 8'h00;
        logic [7:0] csumByte;
        bit         expOk;
        int         expWrites;
        int         bad = 0;
        int         k = 0;
        streamQ.delete();
        wrAddrQ.delete();
        wrDataQ.delete();
        weReadyViol  = 0;
        weBackToBack = 0;
        fallCyc      = -1;
        lastWeCyc    = -1;
        streamQ.push_back(n[15:8]);
        streamQ.push_back(n[7:0]);
        if (inRange) begin
            for (int i = 0; i < n; i++) begin
                streamQ.push_back(wordQ[i][15:8]);
                streamQ.push_back(wordQ[i][7:0]);
                xorSum = xorSum ^ wordQ[i][15:8] ^ wordQ[i][7:0];
            end
        end
        csumByte = corrupt ? (xorSum ^ 8'h01) : xorSum;
        $display("[TB] load %s: N=%0d mode=%0d checksum=%02h", tag, n, mode, csumByte);
`ifdef ROM_LOADER_CHECKSUM_EN
        if (inRange) streamQ.push_back(csumByte);
        expOk = inRange && !corrupt;
`else
        expOk = inRange;
`endif
        expWrites = inRange ? n : 0;
        pulseStart();
        applyStimulus(mode, noise, tag);
        while (busy && k < 200) begin
            @(negedge clk);
            k++;
        end
        checkOutput({tag, "_busyCleared"}, busy, 1'b0);
        checkOutput({tag, "_done"}, done, expOk);
        checkOutput({tag, "_error"}, error, !expOk);
        checkOutput({tag, "_cpuReset"}, cpu_reset, !expOk);
        checkOutput({tag, "_inReadyIdle"}, in_ready, 1'b0);
        checkOutput({tag, "_writeCount"}, wrAddrQ.size(), expWrites);
        for (int i = 0; i < wrAddrQ.size() && i < expWrites; i++) begin
            if (wrAddrQ[i] !== i[AW-1:0] || wrDataQ[i] !== wordQ[i]) bad++;
        end
        checkOutput({tag, "_writeContents"}, bad, 0);
        checkOutput({tag, "_readyDuringWrite"}, weReadyViol, 0);
        checkOutput({tag, "_weSingleCycle"}, weBackToBack, 0);
`ifndef ROM_LOADER_CHECKSUM_EN
        if (expOk && n > 0) checkOutput({tag, "_cpuResetFall"}, fallCyc, lastWeCyc + 1);
`endif
    endtask

    initial begin
        int n;
        int k;
        reset    = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_byte  = 8'h00;
        repeat (3) @(negedge clk);
        checkOutput("rst_inReady", in_ready, 1'b0);
        checkOutput("rst_romWe", rom_we, 1'b0);
        checkOutput("rst_romAddr", rom_addr, 0);
        checkOutput("rst_romData", rom_data, 16'h0000);
        checkOutput("rst_cpuReset", cpu_reset, 1'b1);
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_done", done, 1'b0);
        checkOutput("rst_error", error, 1'b0);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("idle_cpuReset", cpu_reset, 1'b1);
        checkOutput("idle_busy", busy, 1'b0);

        wordQ = {16'h1234, 16'hABCD};
        runLoad("basic", 2, 0, 1'b0, 1'b0);
        checkOutput("basic_addr0", wrAddrQ[0], 0);
        checkOutput("basic_data0", wrDataQ[0], 16'h1234);
        checkOutput("basic_addr1", wrAddrQ[1], 1);
        checkOutput("basic_data1", wrDataQ[1], 16'hABCD);

        runLoad("toggle", 2, 1, 1'b0, 1'b0);
        runLoad("zero", 0, 0, 1'b0, 1'b0);
        runLoad("over", 4097, 0, 1'b0, 1'b0);

        wordQ.delete();
        for (int i = 0; i < CAP; i++) wordQ.push_back(16'(i));
        runLoad("full", CAP, 0, 1'b0, 1'b0);
        checkOutput("full_lastAddr", wrAddrQ[CAP-1], CAP - 1);
        checkOutput("full_lastData", wrDataQ[CAP-1], 16'h0FFF);

        // Abort a 5-word load with reset once three words have been written.
        wordQ = {16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555};
        streamQ.delete();
        wrAddrQ.delete();
        wrDataQ.delete();
        streamQ = {8'h00, 8'h05, 8'h11, 8'h11, 8'h22, 8'h22, 8'h33, 8'h33};
        pulseStart();
        applyStimulus(0, 1'b0, "midReset");
        k = 0;
        while (wrAddrQ.size() < 3 && k < 20) begin
            @(negedge clk);
            k++;
        end
        checkOutput("midReset_writes", wrAddrQ.size(), 3);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checkOutput("midReset_cpuReset", cpu_reset, 1'b1);
        checkOutput("midReset_busy", busy, 1'b0);
        checkOutput("midReset_inReady", in_ready, 1'b0);
        checkOutput("midReset_done", done, 1'b0);
        checkOutput("midReset_romWe", rom_we, 1'b0);
        runLoad("afterReset", 5, 2, 1'b1, 1'b0);

        for (int t = 0; t < 6; t++) begin
            n = $urandom_range(1, 24);
            wordQ.delete();
            for (int i = 0; i < n; i++) wordQ.push_back(16'($urandom));
            runLoad("rand", n, $urandom_range(0, 2), 1'b1, 1'b0);
        end
        n = $urandom_range(CAP + 1, 65535);
        runLoad("randOver", n, 2, 1'b1, 1'b0);

`ifdef ROM_LOADER_CHECKSUM_EN
        wordQ = {16'h1234};
        runLoad("csumGood", 1, 0, 1'b0, 1'b0);
        runLoad("csumBad", 1, 0, 1'b0, 1'b1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
